// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB-first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add a registered signed-overflow output alongside diff.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             borrow_ff;
  logic [CW-1:0]    cnt;
  logic             d, bo, last, accept;
`ifdef SERIAL_SUB_OVF_EN
  logic             amsb, bmsb;
`endif

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d  = sa[0] ^ sb[0] ^ borrow_ff;
    bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow_ff);
  end

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb      <= 1'b0;
      bmsb      <= 1'b0;
      overflow  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && accept) begin
        sa        <= a;
        sb        <= b;
        borrow_ff <= 1'b0;
        cnt       <= '0;
`ifdef SERIAL_SUB_OVF_EN
        amsb      <= a[WIDTH-1];
        bmsb      <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
        sa        <= {1'b0, sa[WIDTH-1:1]};
        sb        <= {1'b0, sb[WIDTH-1:1]};
        res       <= {d, res[WIDTH-1:1]};
        borrow_ff <= bo;
        cnt       <= cnt + CW'(1);
        // The final difference bit lands in the MSB on the same edge it is published
        if (last) begin
          diff     <= {d, res[WIDTH-1:1]};
          borrow   <= bo;
`ifdef SERIAL_SUB_OVF_EN
          overflow <= (amsb != bmsb) && (d != amsb);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8), covering latency,
// backpressure, mid-run reset, back-to-back throughput and the optional overflow output.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  int compared   = 0;
  int mismatched = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for exactly one accept edge; assumes the block is in IDLE.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    tick();
    in_valid = 1'b0;
    a        = 8'hC3;
    b        = 8'h3C;
  endtask

  // Waits (bounded) for out_valid, then checks the held result.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expDiff, input logic expBorrow);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_diff"}, 32'(diff), 32'(expDiff));
    chk({tag, "_borrow"}, 32'(borrow), 32'(expBorrow));
    chk({tag, "_inready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_valid", 32'(out_valid), 32'd0);
    chk("consume_inready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int accepts[$];
    int validCount;
    int edgeIdx;
    logic wasReady;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("reset_inready", 32'(in_ready), 32'd1);
    chk("reset_outvalid", 32'(out_valid), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_borrow", 32'(borrow), 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x5A - 0x1C with exact latency check: valid appears only after the 8th bit edge
    applyStimulus(8'h5A, 8'h1C);
    chk("t1_inready_after_accept", 32'(in_ready), 32'd0);
    for (int i = 1; i < WIDTH; i++) tick();
    chk("t1_valid_before_E8", 32'(out_valid), 32'd0);
    chk("t1_inready_before_E8", 32'(in_ready), 32'd0);
    tick();
    chk("t1_valid_at_E8", 32'(out_valid), 32'd1);
    checkOutput("t1", 8'h3E, 1'b0);
    consume();

    applyStimulus(8'h00, 8'h01);
    checkOutput("t2", 8'hFF, 1'b1);
    consume();

    applyStimulus(8'hA5, 8'hA5);
    checkOutput("t3", 8'h00, 1'b0);
    consume();

    // Backpressure: result held while new operands wait on in_valid
    applyStimulus(8'h30, 8'h10);
    checkOutput("bp", 8'h20, 1'b0);
    in_valid = 1'b1;
    a        = 8'h11;
    b        = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_diff", 32'(diff), 32'h20);
      chk("bp_hold_borrow", 32'(borrow), 32'd0);
      chk("bp_hold_inready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_inready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    checkOutput("bp_next", 8'hEF, 1'b1);
    consume();

    // Reset mid-RUN after three bit edges discards the operation
    applyStimulus(8'h77, 8'h11);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_outvalid", 32'(out_valid), 32'd0);
    chk("rst_inready", 32'(in_ready), 32'd1);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_no_output", 32'(out_valid), 32'd0);
    applyStimulus(8'h10, 8'h20);
    checkOutput("post_rst", 8'hF0, 1'b1);
    consume();

    // Back-to-back with out_ready tied high: accept spacing WIDTH+2, valid one cycle each
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    a          = 8'h09;
    b          = 8'h04;
    validCount = 0;
    for (edgeIdx = 1; edgeIdx <= 30; edgeIdx++) begin
      wasReady = in_ready;
      tick();
      if (wasReady) accepts.push_back(edgeIdx);
      if (out_valid) begin
        validCount++;
        chk("b2b_diff", 32'(diff), 32'h05);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accept_count", 32'(accepts.size()), 32'd3);
    if (accepts.size() >= 3) begin
      chk("b2b_spacing0", 32'(accepts[1] - accepts[0]), 32'(WIDTH + 2));
      chk("b2b_spacing1", 32'(accepts[2] - accepts[1]), 32'(WIDTH + 2));
    end
    chk("b2b_valid_cycles", 32'(validCount), 32'd3);
    tick();
    chk("b2b_idle_inready", 32'(in_ready), 32'd1);

`ifdef SERIAL_SUB_OVF_EN
    applyStimulus(8'h80, 8'h01);
    checkOutput("ovf1", 8'h7F, 1'b0);
    chk("ovf1_overflow", 32'(overflow), 32'd1);
    consume();
    chk("ovf1_retained", 32'(overflow), 32'd1);

    applyStimulus(8'h7F, 8'hFF);
    checkOutput("ovf2", 8'h80, 1'b1);
    chk("ovf2_overflow", 32'(overflow), 32'd1);
    consume();

    applyStimulus(8'h05, 8'h03);
    checkOutput("ovf3", 8'h02, 1'b0);
    chk("ovf3_overflow", 32'(overflow), 32'd0);
    consume();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
